// File: rtl/key_event_gen.sv
// Turns a level keycode into debounced one-frame key events with optional auto-repeat.
// Events, held key and event count are all registered on frame_clk.
module key_event_gen #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6,
    parameter int REPEAT_EN       = 1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_raw,
    output logic [7:0] key,
    output logic       key_valid,
    output logic [7:0] key_held,
    output logic [7:0] event_count
);

    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] RD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RP = 8'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_REPEAT
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cand, w_cand_nxt;
    logic [3:0] r_dcnt, w_dcnt_nxt;
    logic [7:0] r_rcnt, w_rcnt_nxt;
    logic       w_emit;
    logic [3:0] w_dcnt_inc;
    logic [7:0] w_rcnt_inc;
    logic       w_raw_zero;
    logic       w_raw_match;

    logic [7:0] r_key;
    logic       r_key_valid;
    logic [7:0] r_key_held;
    logic [7:0] r_event_count;

    assign w_dcnt_inc  = r_dcnt + 4'd1;
    assign w_rcnt_inc  = r_rcnt + 8'd1;
    assign w_raw_zero  = (keycode_raw == 8'h00);
    assign w_raw_match = (keycode_raw == r_cand);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_cand        <= 8'h00;
            r_dcnt        <= 4'd0;
            r_rcnt        <= 8'd0;
            r_key         <= 8'h00;
            r_key_valid   <= 1'b0;
            r_key_held    <= 8'h00;
            r_event_count <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_key       <= w_emit ? w_cand_nxt : 8'h00;
            r_key_valid <= w_emit;
            r_key_held  <= (w_state_nxt == S_HELD || w_state_nxt == S_REPEAT) ? w_cand_nxt : 8'h00;
            if (w_emit)
                r_event_count <= r_event_count + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_dcnt_nxt  = r_dcnt;
        w_rcnt_nxt  = r_rcnt;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_raw_zero) begin
                    w_cand_nxt = keycode_raw;
                    w_dcnt_nxt = 4'd1;
                    if (DF == 4'd1) begin
                        w_emit      = 1'b1;
                        w_rcnt_nxt  = 8'd0;
                        w_state_nxt = S_HELD;
                    end else begin
                        w_state_nxt = S_DEBOUNCE;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_raw_match) begin
                    w_dcnt_nxt = w_dcnt_inc;
                    // >= keeps a single-frame debounce from stalling after a key change
                    if (w_dcnt_inc >= DF) begin
                        w_emit      = 1'b1;
                        w_dcnt_nxt  = DF;
                        w_rcnt_nxt  = 8'd0;
                        w_state_nxt = S_HELD;
                    end
                end else if (w_raw_zero) begin
                    w_dcnt_nxt  = 4'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cand_nxt = keycode_raw;
                    w_dcnt_nxt = 4'd1;
                end
            end
            S_HELD, S_REPEAT: begin
                if (w_raw_match) begin
                    if (r_state == S_REPEAT) begin
                        if (w_rcnt_inc == RP) begin
                            w_emit     = 1'b1;
                            w_rcnt_nxt = 8'd0;
                        end else begin
                            w_rcnt_nxt = w_rcnt_inc;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (w_rcnt_inc == RD) begin
                            w_emit      = 1'b1;
                            w_rcnt_nxt  = 8'd0;
                            w_state_nxt = S_REPEAT;
                        end else begin
                            w_rcnt_nxt = w_rcnt_inc;
                        end
                    end
                end else if (w_raw_zero) begin
                    // release beats a repeat threshold reached on the same edge
                    w_rcnt_nxt  = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rcnt_nxt  = 8'd0;
                    w_cand_nxt  = keycode_raw;
                    w_dcnt_nxt  = 4'd1;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign key         = r_key;
    assign key_valid   = r_key_valid;
    assign key_held    = r_key_held;
    assign event_count = r_event_count;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: default, no-repeat and single-frame-debounce instances share stimulus.
module tb_key_event_gen;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] raw;

    logic [7:0] key,  key_held,  event_count;
    logic       key_valid;
    logic [7:0] nr_key, nr_key_held, nr_event_count;
    logic       nr_key_valid;
    logic [7:0] d1_key, d1_key_held, d1_event_count;
    logic       d1_key_valid;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    key_event_gen dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode_raw(raw),
        .key(key), .key_valid(key_valid), .key_held(key_held), .event_count(event_count)
    );

    key_event_gen #(.REPEAT_EN(0)) dut_nr (
        .frame_clk(frame_clk), .Reset(Reset), .keycode_raw(raw),
        .key(nr_key), .key_valid(nr_key_valid), .key_held(nr_key_held), .event_count(nr_event_count)
    );

    key_event_gen #(.DEBOUNCE_FRAMES(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_d1 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode_raw(raw),
        .key(d1_key), .key_valid(d1_key_valid), .key_held(d1_key_held), .event_count(d1_event_count)
    );

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        raw = 8'h00;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        raw = 8'h44;
        #3;
        checks++;
        if ({key, key_valid, key_held, event_count} !== 25'd0) begin
            errors++;
            $display("FAIL reset_async got key=%h v=%b held=%h cnt=%h want all 0", key, key_valid, key_held, event_count);
        end
        step(); step(); step();
        checks++;
        if ({key, key_valid, key_held, event_count, nr_key_held, d1_key, d1_key_held} !== 49'd0) begin
            errors++;
            $display("FAIL reset_held got key=%h held=%h d1key=%h d1held=%h want 0", key, key_held, d1_key, d1_key_held);
        end
        Reset = 1'b0;
        raw = 8'h00;
        step();
    endtask

    task automatic test_basic_press();
        do_reset();
        raw = 8'h1E;
        step(); step();
        checks++;
        if (key_valid !== 1'b0 || key !== 8'h00) begin
            errors++;
            $display("FAIL basic_early got key=%h v=%b want 00/0", key, key_valid);
        end
        step();
        checks++;
        if (key !== 8'h1E || key_valid !== 1'b1 || key_held !== 8'h1E || event_count !== 8'h01) begin
            errors++;
            $display("FAIL basic_emit got key=%h v=%b held=%h cnt=%h want 1e/1/1e/01", key, key_valid, key_held, event_count);
        end
        raw = 8'h00;
        step();
        checks++;
        if (key !== 8'h00 || key_valid !== 1'b0 || key_held !== 8'h00 || event_count !== 8'h01) begin
            errors++;
            $display("FAIL basic_release got key=%h v=%b held=%h cnt=%h want 00/0/00/01", key, key_valid, key_held, event_count);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [5] = '{8'h05, 8'h05, 8'h1A, 8'h1A, 8'h1A};
        int evs = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            raw = seq[i];
            step();
            if (key_valid) evs++;
        end
        checks++;
        if (key !== 8'h1A || key_valid !== 1'b1 || evs !== 1 || key_held !== 8'h1A) begin
            errors++;
            $display("FAIL bounce got key=%h v=%b evs=%0d held=%h want 1a/1/1/1a", key, key_valid, evs, key_held);
        end
    endtask

    task automatic test_key_change_in_held();
        do_reset();
        raw = 8'h1E;
        step(); step(); step();
        raw = 8'h2B;
        step();
        checks++;
        if (key_valid !== 1'b0 || key_held !== 8'h00) begin
            errors++;
            $display("FAIL change_release got v=%b held=%h want 0/00", key_valid, key_held);
        end
        step(); step();
        checks++;
        if (key !== 8'h2B || event_count !== 8'h02) begin
            errors++;
            $display("FAIL change_emit got key=%h cnt=%h want 2b/02", key, event_count);
        end
        raw = 8'h00;
        step();
    endtask

    task automatic test_repeat();
        int ev_at [8];
        int n = 0;
        int nnr = 0;
        logic bad_key = 1'b0;
        do_reset();
        for (int e = 1; e <= 49; e++) begin
            raw = (e <= 48) ? 8'h13 : 8'h00;
            step();
            if (key_valid) begin
                if (n < 8) ev_at[n] = e;
                n++;
                if (key !== 8'h13) bad_key = 1'b1;
            end
            if (nr_key_valid) nnr++;
        end
        checks++;
        if (n !== 4 || bad_key) begin
            errors++;
            $display("FAIL repeat_count got %0d events badkey=%b want 4/0", n, bad_key);
        end else begin
            checks++;
            if (ev_at[0] !== 3 || ev_at[1] !== 33 || ev_at[2] !== 39 || ev_at[3] !== 45) begin
                errors++;
                $display("FAIL repeat_times got %0d %0d %0d %0d want 3 33 39 45", ev_at[0], ev_at[1], ev_at[2], ev_at[3]);
            end
        end
        checks++;
        if (nnr !== 1 || nr_event_count !== 8'h01) begin
            errors++;
            $display("FAIL norepeat got evs=%0d cnt=%h want 1/01", nnr, nr_event_count);
        end
    endtask

    task automatic test_release_on_threshold();
        int n = 0;
        do_reset();
        for (int e = 1; e <= 33; e++) begin
            raw = (e <= 32) ? 8'h29 : 8'h00;
            step();
            if (key_valid) n++;
        end
        checks++;
        if (n !== 1 || key_valid !== 1'b0 || key_held !== 8'h00) begin
            errors++;
            $display("FAIL release_thresh got evs=%0d v=%b held=%h want 1/0/00", n, key_valid, key_held);
        end
        raw = 8'h29;
        step(); step();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL repress_early got v=%b want 0", key_valid);
        end
        step();
        checks++;
        if (key !== 8'h29 || key_valid !== 1'b1 || event_count !== 8'h02) begin
            errors++;
            $display("FAIL repress_emit got key=%h v=%b cnt=%h want 29/1/02", key, key_valid, event_count);
        end
        raw = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 257; p++) begin
            raw = 8'h07;
            step(); step(); step();
            raw = 8'h00;
            step();
            if (p == 255) begin
                checks++;
                if (event_count !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_256 got cnt=%h want 00", event_count);
                end
            end
        end
        checks++;
        if (event_count !== 8'h01) begin
            errors++;
            $display("FAIL wrap_257 got cnt=%h want 01", event_count);
        end
    endtask

    task automatic test_reset_on_accept();
        do_reset();
        raw = 8'h15;
        step(); step();
        Reset = 1'b1;
        step();
        checks++;
        if (key !== 8'h00 || key_valid !== 1'b0 || event_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_accept got key=%h v=%b cnt=%h want 00/0/00", key, key_valid, event_count);
        end
        Reset = 1'b0;
        step(); step();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_redebounce_early got v=%b want 0", key_valid);
        end
        step();
        checks++;
        if (key !== 8'h15 || key_valid !== 1'b1 || event_count !== 8'h01) begin
            errors++;
            $display("FAIL reset_redebounce got key=%h v=%b cnt=%h want 15/1/01", key, key_valid, event_count);
        end
        raw = 8'h00;
        step();
    endtask

    task automatic test_single_frame_debounce();
        int n = 0;
        do_reset();
        raw = 8'h22;
        step();
        checks++;
        if (d1_key !== 8'h22 || d1_key_valid !== 1'b1 || d1_key_held !== 8'h22 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL df1_emit got key=%h v=%b held=%h dflt_v=%b want 22/1/22/0", d1_key, d1_key_valid, d1_key_held, key_valid);
        end
        for (int e = 1; e <= 6; e++) begin
            step();
            if (d1_key_valid) n++;
        end
        checks++;
        if (n !== 2 || d1_event_count !== 8'h03) begin
            errors++;
            $display("FAIL df1_repeat got evs=%0d cnt=%h want 2/03", n, d1_event_count);
        end
        raw = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_bounce();
        test_key_change_in_held();
        test_repeat();
        test_release_on_threshold();
        test_reset_on_accept();
        test_single_frame_debounce();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
